// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store,
// running each access for a fixed number of wait states and acknowledging with a one-cycle pulse.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_CYCLES  = 2,
    parameter int MAX_DATA_RUN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [1:0] RUN_LIMIT = 2'(MAX_DATA_RUN);

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic [1:0]        run_reg;
    logic              grant_d_reg;
    logic              mem_en_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              if_ack_reg;
    logic              d_ack_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              busy_reg;
    logic              fetch_wins;

    // Data normally wins; fetch wins only when it is alone or the data run hit its limit.
    assign fetch_wins = if_req && (!d_req || (run_reg == RUN_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            run_reg       <= '0;
            grant_d_reg   <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_ack_reg    <= 1'b0;
            d_ack_reg     <= 1'b0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (if_req || d_req) begin
                        state_reg   <= ACCESS;
                        cnt_reg     <= WAIT_INIT;
                        busy_reg    <= 1'b1;
                        mem_en_reg  <= 1'b1;
                        grant_d_reg <= !fetch_wins;
                        if (fetch_wins) begin
                            mem_addr_reg  <= if_addr;
                            mem_we_reg    <= 1'b0;
                            mem_wdata_reg <= '0;
                            run_reg       <= '0;
                        end else begin
                            mem_addr_reg  <= d_addr;
                            mem_we_reg    <= d_we;
                            mem_wdata_reg <= d_wdata;
                            if (run_reg != 2'd3) begin
                                run_reg <= run_reg + 2'd1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        // Last access cycle: memory data is valid now, so capture it for the ack cycle.
                        state_reg     <= RESP;
                        mem_en_reg    <= 1'b0;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                        if (grant_d_reg) begin
                            d_ack_reg   <= 1'b1;
                            d_rdata_reg <= mem_rdata;
                        end else begin
                            if_ack_reg   <= 1'b1;
                            if_rdata_reg <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state_reg  <= IDLE;
                    if_ack_reg <= 1'b0;
                    d_ack_reg  <= 1'b0;
                    busy_reg   <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_ack    = if_ack_reg;
    assign d_ack     = d_ack_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant rule, fixed access phases, word memory).
module tb_mem_port_arbiter;

    localparam int W    = 2;
    localparam int MAXR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_ack, d_ack, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        b_if_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
    logic [31:0] b_if_addr = '0, b_d_addr = '0, b_d_wdata = '0;
    logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W), .MAX_DATA_RUN(MAXR)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .MAX_DATA_RUN(MAXR)) dut_w0 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // 16-word memory indexed by address bits [5:2]; loaded while reset is held.
    logic [31:0] mem [16];
    logic        load_en = 1'b0;
    logic [3:0]  load_idx = '0;
    logic [31:0] load_val = '0;
    assign mem_rdata   = mem[mem_addr[5:2]];
    assign b_mem_rdata = {16'hB0B0, b_mem_addr[15:0]};
    always @(posedge clk) begin
        if (load_en) mem[load_idx] <= load_val;
        else if (mem_en && mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    end

    // Reference model state
    logic [31:0] ref_mem [16];
    int          k = 0;
    bit          m_out = 1'b0, m_isd = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    int          m_g = 0, m_run = 0, free_at = 0;
    int          order_bits = 0, order_n = 0;
    int          last_if_ack = 0, last_d_ack = 0, last_grant = 0;
    logic [31:0] last_if_rdata = '0, last_d_rdata = '0;
    int          en_cnt = 0, we_cnt = 0, busy_cnt = 0, dack_cnt = 0;
    int          pass_cnt = 0, fail_cnt = 0, chk_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req_fetch(input logic [31:0] a);
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic req_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
    endtask

    // One clock: decide the model's grant at this edge, then compare every output of dut.
    // An access granted at edge E is in ACCESS after edges E..E+W and acks after edge E+W+1.
    task automatic step();
        int ph;
        bit fw, act, granted;
        @(posedge clk);
        #1;
        k++;
        granted = 1'b0;
        if (rst && !m_out && k >= free_at && (if_req || d_req)) begin
            fw         = if_req && (!d_req || m_run == MAXR);
            m_out      = 1'b1;
            m_isd      = !fw;
            m_g        = k;
            last_grant = k;
            granted    = 1'b1;
            order_bits = (order_bits << 1) | (fw ? 1 : 0);
            order_n++;
            if (fw) begin
                m_addr = if_addr; m_we = 1'b0; m_wdata = '0; m_run = 0;
            end else begin
                m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
                if (m_run < 3) m_run++;
            end
        end
        ph  = m_out ? (k - m_g) : -1;
        act = m_out && ph <= W;
        en_cnt   += int'(mem_en);
        we_cnt   += int'(mem_we);
        busy_cnt += int'(busy);
        dack_cnt += int'(d_ack);
        chk("busy", 32'(busy), 32'(m_out && ph <= W + 1));
        chk("mem_en", 32'(mem_en), 32'(act));
        chk("mem_we", 32'(mem_we), 32'(act && m_we));
        if (act) begin
            chk("mem_addr", mem_addr, m_addr);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_ack", 32'(if_ack), 32'(m_out && ph == W + 1 && !m_isd));
        chk("d_ack", 32'(d_ack), 32'(m_out && ph == W + 1 && m_isd));
        if (m_out && ph == W + 1) begin
            if (!m_isd) begin
                chk("if_rdata", if_rdata, ref_mem[m_addr[5:2]]);
                last_if_ack = k; last_if_rdata = if_rdata; if_req = 1'b0;
                $display("txn fetch addr=%h rdata=%h grant=%0d ack=%0d", m_addr, if_rdata, m_g, k);
            end else begin
                if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
                else chk("d_rdata", d_rdata, ref_mem[m_addr[5:2]]);
                last_d_ack = k; last_d_rdata = d_rdata; d_req = 1'b0;
                $display("txn %s addr=%h data=%h grant=%0d ack=%0d", m_we ? "store" : "load",
                         m_addr, m_we ? m_wdata : d_rdata, m_g, k);
            end
            m_out   = 1'b0;
            free_at = k + 2;
        end
        // The winner's inputs are sampled only at the grant edge; disturb them afterwards.
        if (granted && m_out) begin
            if (!m_isd) if_addr = $urandom();
            else begin
                d_addr = $urandom(); d_wdata = $urandom(); d_we = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((m_out || if_req || d_req) && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain_pending", 32'(m_out || if_req || d_req), 32'd0);
    endtask

    initial begin
        int b_en, b_bz, b_ack_k, b_start, n;
        logic [31:0] b_data;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            load_en  = 1'b1;
            load_idx = 4'(i);
            load_val = (i == 0) ? 32'h8C22_0004 : 32'h1000_0001 + 32'(i) * 32'h0101_0101;
            ref_mem[i] = load_val;
        end
        @(posedge clk); #1;
        load_en = 1'b0;

        // Reset state
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_w0_busy", 32'(b_busy), 32'd0);
        rst = 1'b1;
        step();

        // Single fetch from 0x40
        en_cnt = 0; we_cnt = 0; dack_cnt = 0;
        req_fetch(32'h0000_0040);
        drain(20);
        step();
        chk("fetch_en_cycles", 32'(en_cnt), 32'd3);
        chk("fetch_we_cycles", 32'(we_cnt), 32'd0);
        chk("fetch_latency_edges", 32'(last_if_ack - last_grant), 32'(W + 1));
        chk("fetch_word", last_if_rdata, 32'h8C22_0004);
        chk("fetch_no_dack", 32'(dack_cnt), 32'd0);

        // Simultaneous requests: data first, fetch ack W+3 cycles after data ack
        order_bits = 0; order_n = 0;
        req_fetch(32'h0000_0044);
        req_data(1'b0, 32'h0000_0048, 32'h0);
        drain(40);
        chk("sim_grants", 32'(order_n), 32'd2);
        chk("sim_order", 32'(order_bits), 32'b01);
        chk("sim_gap", 32'(last_if_ack - last_d_ack), 32'(W + 3));

        // Store then load
        en_cnt = 0; we_cnt = 0;
        req_data(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        drain(20);
        chk("store_we_cycles", 32'(we_cnt), 32'd3);
        chk("store_en_cycles", 32'(en_cnt), 32'd3);
        req_data(1'b0, 32'h0000_0100, 32'h0);
        drain(20);
        chk("load_after_store", last_d_rdata, 32'hDEAD_BEEF);

        // Reset during the second ACCESS cycle of a fetch
        req_fetch(32'h0000_0050);
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_if_ack", 32'(if_ack), 32'd0);
        chk("mid_rst_d_ack", 32'(d_ack), 32'd0);
        chk("mid_rst_if_rdata", if_rdata, 32'd0);
        chk("mid_rst_d_rdata", d_rdata, 32'd0);
        m_out = 1'b0; m_run = 0; free_at = 0; if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        req_fetch(32'h0000_0054);
        drain(20);
        chk("post_rst_latency", 32'(last_if_ack - last_grant), 32'(W + 1));
        chk("post_rst_word", last_if_rdata, ref_mem[5]);

        // Starvation guard: data held continuously, fetch pending
        order_bits = 0; order_n = 0;
        req_fetch(32'h0000_0060);
        req_data(1'b0, 32'h0000_0064, 32'h0);
        n = 0;
        while (order_n < 6 && n < 200) begin
            step();
            if (!d_req) req_data(1'($urandom_range(0, 1)), $urandom(), $urandom());
            if (!if_req) req_fetch($urandom());
            n++;
        end
        chk("starve_order", 32'(order_bits), 32'b001001);
        drain(60);

        // WAIT_CYCLES=0 instance: single load
        b_en = 0; b_bz = 0; b_ack_k = -1; b_data = '0; b_start = k;
        b_d_we = 1'b0; b_d_addr = 32'h0000_0238; b_d_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            b_en += int'(b_mem_en);
            b_bz += int'(b_busy);
            if (b_d_ack) begin
                b_ack_k = k; b_data = b_d_rdata; b_d_req = 1'b0;
                $display("txn w0 load addr=%h rdata=%h ack=%0d", b_d_addr, b_d_rdata, k);
            end
        end
        chk("w0_en_cycles", 32'(b_en), 32'd1);
        chk("w0_busy_cycles", 32'(b_bz), 32'd2);
        chk("w0_latency_edges", 32'(b_ack_k - (b_start + 1)), 32'd1);
        chk("w0_rdata", b_data, 32'hB0B0_0238);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step();
            if (!if_req && $urandom_range(0, 3) == 0) req_fetch($urandom());
            if (!d_req && $urandom_range(0, 3) == 0)
                req_data(1'($urandom_range(0, 1)), $urandom(), $urandom());
        end
        drain(60);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
